sensor_monitor: RTL and testbench

//  N-channel successor to the single-bit sensor latch. Each channel debounces
//  its raw sensor input, then drives a registered detect flag in one of three

---
 rtl/sensor_monitor.sv | 179 +++++++++++++++++
 tb/tb_sensor_monitor.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_monitor.sv
`timescale 1ns/1ps
// sensor_monitor: N-channel debounced sensor monitor.
// Each channel filters its raw input, then a small per-channel FSM drives a
// registered detect flag in FOLLOW, STRETCH or LATCH mode. A saturating
// counter tallies filtered rising edges across all channels.
// Handshake: none. Inputs are level signals sampled on every rising CLK edge,
// and outputs are valid from the edge that produced them.
module sensor_monitor #(
   parameter int N     = 4,
   parameter int DEB   = 3,
   parameter int HOLD  = 8,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             MR,
   input  logic [N-1:0]     x,
   input  logic [1:0]       mode,
   input  logic [N-1:0]     clr,
   input  logic             cnt_clr,
   output logic [N-1:0]     z,
   output logic             any,
   output logic [CNT_W-1:0] evt_cnt,
   output logic [2*N-1:0]   dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      HOLDING = 2'd2,
      LATCHED = 2'd3
   } ch_state_t;

   localparam logic [3:0]       DEB_LAST  = 4'(DEB - 1);
   localparam logic [7:0]       HOLD_INIT = 8'(HOLD);
   localparam int               SW        = ((CNT_W > 6) ? CNT_W : 6) + 1;
   localparam logic [SW-1:0]    CNT_MAX   = SW'({CNT_W{1'b1}});

   ch_state_t        state_q [N];
   ch_state_t        state_d [N];
   logic [3:0]       deb_q   [N];
   logic [3:0]       deb_d   [N];
   logic [7:0]       hold_q  [N];
   logic [7:0]       hold_d  [N];
   logic [N-1:0]     f_q, f_d;
   logic [N-1:0]     rise, fall;
   logic [N-1:0]     z_q, z_d;
   logic [5:0]       rise_cnt;
   logic [SW-1:0]    sum;
   logic [CNT_W-1:0] evt_q, evt_d;
   logic             mode_stretch, mode_latch, mode_follow;

   // Mode 11 is not a real mode and behaves as FOLLOW.
   assign mode_stretch = (mode == 2'b01);
   assign mode_latch   = (mode == 2'b10);
   assign mode_follow  = ~mode_stretch & ~mode_latch;

   // Debounce: count consecutive samples that disagree with the filtered
   // level and toggle the level on the DEB-th one.
   always_comb begin
      f_d  = f_q;
      rise = '0;
      fall = '0;
      for (int i = 0; i < N; i++) begin
         deb_d[i] = '0;
         if (x[i] != f_q[i]) begin
            if (deb_q[i] == DEB_LAST) begin
               f_d[i]  = x[i];
               rise[i] = x[i];
               fall[i] = ~x[i];
            end else begin
               deb_d[i] = deb_q[i] + 4'd1;
            end
         end
      end
   end

   // Channel FSM next state; transitions use the filtered edges decided this
   // same clock, so z follows f with no extra cycle.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         hold_d[i]  = hold_q[i];
         case (state_q[i])
            IDLE: begin
               if (rise[i]) state_d[i] = ACTIVE;
            end
            ACTIVE: begin
               if (fall[i]) begin
                  if (mode_stretch) begin
                     if (HOLD_INIT != 8'd0) begin
                        state_d[i] = HOLDING;
                        hold_d[i]  = HOLD_INIT;
                     end else begin
                        state_d[i] = IDLE;
                     end
                  end else if (mode_latch) begin
                     state_d[i] = LATCHED;
                  end else begin
                     state_d[i] = IDLE;
                  end
               end
            end
            HOLDING: begin
               if (rise[i])               state_d[i] = ACTIVE;
               else if (mode_follow)      state_d[i] = IDLE;
               else if (hold_q[i] == 8'd1) state_d[i] = IDLE;
               else                       hold_d[i]  = hold_q[i] - 8'd1;
            end
            LATCHED: begin
               // f is low here; a rise goes back to ACTIVE and counts as an event.
               if (rise[i]) begin
                  state_d[i] = ACTIVE;
               end else if (mode_follow) begin
                  state_d[i] = IDLE;
               end else if (mode_stretch) begin
                  if (HOLD_INIT != 8'd0) begin
                     state_d[i] = HOLDING;
                     hold_d[i]  = HOLD_INIT;
                  end else begin
                     state_d[i] = IDLE;
                  end
               end else if (clr[i]) begin
                  state_d[i] = IDLE;
               end
            end
            default: state_d[i] = IDLE;
         endcase
         z_d[i] = (state_d[i] != IDLE);
      end
   end

   // Event counter next value: popcount of filtered rises, saturating.
   always_comb begin
      rise_cnt = '0;
      for (int i = 0; i < N; i++) begin
         rise_cnt = rise_cnt + 6'(rise[i]);
      end
      sum = SW'(evt_q) + SW'(rise_cnt);
      if (cnt_clr)            evt_d = '0;
      else if (sum > CNT_MAX) evt_d = {CNT_W{1'b1}};
      else                    evt_d = CNT_W'(sum);
   end

   // State register for filters, FSMs, detect flags and counter.
   always_ff @(posedge CLK) begin
      if (MR) begin
         f_q   <= '0;
         z_q   <= '0;
         evt_q <= '0;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= IDLE;
            deb_q[i]   <= '0;
            hold_q[i]  <= '0;
         end
      end else begin
         f_q   <= f_d;
         z_q   <= z_d;
         evt_q <= evt_d;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            deb_q[i]   <= deb_d[i];
            hold_q[i]  <= hold_d[i];
         end
      end
   end

   // Debug view of every channel state, two bits per channel.
   always_comb begin
      dbg_state = '0;
      for (int i = 0; i < N; i++) begin
         dbg_state[2*i +: 2] = state_q[i];
      end
   end

   assign z       = z_q;
   assign any     = |z_q;
   assign evt_cnt = evt_q;

endmodule

// File: tb/tb_sensor_monitor.sv
`timescale 1ns/1ps
// Bench for sensor_monitor: directed scenario tasks plus a cycle model that
// feeds an expected queue compared against both DUT instances every cycle.
module tb_sensor_monitor;

   localparam int N    = 4;
   localparam int DEB  = 3;
   localparam int HOLD = 8;
   localparam int W    = N + 1 + 8 + 2;

   logic           CLK = 1'b0;
   logic           MR;
   logic [N-1:0]   x;
   logic [1:0]     mode;
   logic [N-1:0]   clr;
   logic           cnt_clr;
   logic [N-1:0]   z, z_s;
   logic           any, any_s;
   logic [7:0]     evt_cnt;
   logic [1:0]     evt_sat;
   logic [2*N-1:0] dbg, dbg_s;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v, got_v;

   // clock / reset block
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout, required completion");
      $fatal(1);
   end

   sensor_monitor #(.N(N), .DEB(DEB), .HOLD(HOLD), .CNT_W(8)) dut (
      .CLK(CLK), .MR(MR), .x(x), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
      .z(z), .any(any), .evt_cnt(evt_cnt), .dbg_state(dbg)
   );

   sensor_monitor #(.N(N), .DEB(DEB), .HOLD(HOLD), .CNT_W(2)) dut_sat (
      .CLK(CLK), .MR(MR), .x(x), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
      .z(z_s), .any(any_s), .evt_cnt(evt_sat), .dbg_state(dbg_s)
   );

   // reference model: run-length filter, channel behaviour, counters
   int           m_st  [N];
   int           m_hc  [N];
   int           m_run [N];
   logic [N-1:0] m_f;
   logic [N-1:0] m_z;
   int           m_cnt8, m_cnt2, m_md, m_rises;
   logic         m_up, m_dn;

   always @(posedge CLK) begin
      if (MR) begin
         for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_hc[i] = 0; m_run[i] = 0; m_f[i] = 1'b0;
         end
         m_cnt8 = 0;
         m_cnt2 = 0;
      end else begin
         m_md    = (mode == 2'b11) ? 0 : int'(mode);
         m_rises = 0;
         for (int i = 0; i < N; i++) begin
            m_up = 1'b0;
            m_dn = 1'b0;
            if (x[i] !== m_f[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_f[i] = x[i]; m_run[i] = 0; m_up = x[i]; m_dn = !x[i];
               end
            end else begin
               m_run[i] = 0;
            end
            if (m_up) m_rises++;
            case (m_st[i])
               0: if (m_up) m_st[i] = 1;
               1: if (m_dn) begin
                     if (m_md == 1) begin
                        if (HOLD > 0) begin m_st[i] = 2; m_hc[i] = HOLD; end
                        else m_st[i] = 0;
                     end else if (m_md == 2) m_st[i] = 3;
                     else m_st[i] = 0;
                  end
               2: if (m_up) m_st[i] = 1;
                  else if (m_md == 0) m_st[i] = 0;
                  else begin
                     m_hc[i]--;
                     if (m_hc[i] == 0) m_st[i] = 0;
                  end
               default: if (m_up) m_st[i] = 1;
                  else if (m_md == 0) m_st[i] = 0;
                  else if (m_md == 1) begin
                     if (HOLD > 0) begin m_st[i] = 2; m_hc[i] = HOLD; end
                     else m_st[i] = 0;
                  end else if (clr[i]) m_st[i] = 0;
            endcase
         end
         if (cnt_clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
         end else begin
            m_cnt8 = (m_cnt8 + m_rises > 255) ? 255 : m_cnt8 + m_rises;
            m_cnt2 = (m_cnt2 + m_rises > 3) ? 3 : m_cnt2 + m_rises;
         end
      end
      for (int i = 0; i < N; i++) m_z[i] = (m_st[i] != 0);
      exp_q.push_back({m_z, |m_z, 8'(m_cnt8), 2'(m_cnt2)});
   end

   // scoreboard: pop one expectation per cycle, compare both instances
   always @(negedge CLK) begin
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         got_v = {z, any, evt_cnt, evt_sat};
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t got z/any/cnt/sat=%h required %h", $time, got_v, exp_v);
         end
         vectors++;
         if ({z_s, any_s} !== exp_v[W-1 -: N+1]) begin
            miscompares++;
            $display("FAIL scoreboard_sat_z t=%0t got %b required %b", $time, {z_s, any_s}, exp_v[W-1 -: N+1]);
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic test_reset();
      MR = 1'b1; x = '1; mode = 2'b00; clr = '0; cnt_clr = 1'b0;
      ticks(2);
      vectors++;
      if ({z, any, evt_cnt} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got z=%b any=%b cnt=%0d required all 0", z, any, evt_cnt);
      end
      MR = 1'b0; x = '0;
      tick();
      vectors++;
      if (z !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_release z got %b required 0000", z);
      end
   endtask

   task automatic test_debounce();
      x = 4'b0001;
      ticks(2);
      x = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (z[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL deb_glitch z0 got %b required 0", z[0]);
         end
      end
      x = 4'b0001;
      ticks(2);
      vectors++;
      if (z[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL deb_two_samples z0 got %b required 0", z[0]);
      end
      tick();
      vectors++;
      if ({z[0], evt_cnt} !== {1'b1, 8'd1}) begin
         miscompares++;
         $display("FAIL deb_third_sample z0/cnt got %b/%0d required 1/1", z[0], evt_cnt);
      end
      x = 4'b0000;
      ticks(3);
      vectors++;
      if (z[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL follow_release z0 got %b required 0", z[0]);
      end
   endtask

   task automatic test_stretch();
      mode = 2'b01;
      x = 4'b0010; ticks(3);
      x = 4'b0000; ticks(3);
      for (int k = 0; k < HOLD - 1; k++) begin
         tick();
         vectors++;
         if (z[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL stretch_hold cycle %0d z1 got %b required 1", k, z[1]);
         end
      end
      tick();
      vectors++;
      if ({z[1], any} !== 2'b00) begin
         miscompares++;
         $display("FAIL stretch_end z1/any got %b required 00", {z[1], any});
      end
      x = 4'b0010; ticks(3);
      x = 4'b0000; ticks(5);
      x = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (z[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL stretch_repress z1 got %b required 1", z[1]);
         end
      end
      vectors++;
      if (evt_cnt !== 8'd4) begin
         miscompares++;
         $display("FAIL stretch_repress_cnt got %0d required 4", evt_cnt);
      end
      x = 4'b0000; ticks(3 + HOLD);
      mode = 2'b00;
      tick();
   endtask

   task automatic test_latch();
      mode = 2'b10;
      x = 4'b0100; ticks(3);
      x = 4'b0000; ticks(7);
      vectors++;
      if (z[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL latch_hold z2 got %b required 1", z[2]);
      end
      x = 4'b0100; ticks(3);
      clr = 4'b0100; ticks(2);
      vectors++;
      if ({z[2], evt_cnt} !== {1'b1, 8'd6}) begin
         miscompares++;
         $display("FAIL latch_clr_ignored z2/cnt got %b/%0d required 1/6", z[2], evt_cnt);
      end
      clr = 4'b0000;
      x = 4'b0000; ticks(3);
      clr = 4'b0100; tick();
      vectors++;
      if (z[2] !== 1'b0) begin
         miscompares++;
         $display("FAIL latch_clr z2 got %b required 0", z[2]);
      end
      clr = 4'b0000;
      x = 4'b0100; ticks(3);
      x = 4'b0000; ticks(3);
      mode = 2'b00; tick();
      vectors++;
      if ({z[2], evt_cnt} !== {1'b0, 8'd7}) begin
         miscompares++;
         $display("FAIL latch_follow_clear z2/cnt got %b/%0d required 0/7", z[2], evt_cnt);
      end
   endtask

   task automatic test_saturate();
      cnt_clr = 1'b1; tick();
      cnt_clr = 1'b0;
      vectors++;
      if ({evt_cnt, evt_sat} !== 10'd0) begin
         miscompares++;
         $display("FAIL cnt_clr got %0d/%0d required 0/0", evt_cnt, evt_sat);
      end
      x = 4'b0011; ticks(3);
      vectors++;
      if ({evt_cnt, evt_sat} !== {8'd2, 2'd2}) begin
         miscompares++;
         $display("FAIL dual_rise got %0d/%0d required 2/2", evt_cnt, evt_sat);
      end
      x = 4'b0000; ticks(3);
      x = 4'b0101; ticks(3);
      x = 4'b0000; ticks(3);
      x = 4'b1000; ticks(3);
      vectors++;
      if ({evt_cnt, evt_sat} !== {8'd5, 2'd3}) begin
         miscompares++;
         $display("FAIL saturate got %0d/%0d required 5/3", evt_cnt, evt_sat);
      end
      x = 4'b0001; ticks(2);
      cnt_clr = 1'b1; tick();
      cnt_clr = 1'b0;
      vectors++;
      if ({z, evt_cnt, evt_sat} !== {4'b0001, 8'd0, 2'd0}) begin
         miscompares++;
         $display("FAIL clr_drops_rise z/cnt/sat got %b/%0d/%0d required 0001/0/0", z, evt_cnt, evt_sat);
      end
      x = 4'b0000; ticks(3);
   endtask

   task automatic test_reset_mid();
      mode = 2'b01;
      x = 4'b0010; ticks(3);
      x = 4'b0000; ticks(5);
      x = 4'b1000; ticks(2);
      MR = 1'b1; tick();
      vectors++;
      if ({z, any, evt_cnt, evt_sat} !== 15'd0) begin
         miscompares++;
         $display("FAIL reset_mid got z=%b any=%b cnt=%0d sat=%0d required all 0", z, any, evt_cnt, evt_sat);
      end
      MR = 1'b0;
      ticks(2);
      vectors++;
      if (z !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_mid_deb z got %b required 0000", z);
      end
      tick();
      vectors++;
      if ({z, evt_cnt} !== {4'b1000, 8'd1}) begin
         miscompares++;
         $display("FAIL reset_mid_full_deb z/cnt got %b/%0d required 1000/1", z, evt_cnt);
      end
      x = 4'b0000; mode = 2'b00; ticks(3);
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) x[i] = ~x[i];
         end
         if (c % 40 == 0) mode = 2'($urandom_range(0, 3));
         clr     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         cnt_clr = ($urandom_range(0, 29) == 0);
         MR      = ($urandom_range(0, 149) == 0);
         tick();
      end
      MR = 1'b0; x = '0; clr = '0; cnt_clr = 1'b0; mode = 2'b00;
      ticks(4 + HOLD);
   endtask

   initial begin
      MR = 1'b1; x = '0; mode = 2'b00; clr = '0; cnt_clr = 1'b0;
      test_reset();
      test_debounce();
      test_stretch();
      test_latch();
      test_saturate();
      test_reset_mid();
      test_random();
      @(negedge CLK);
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL queue_drain got %0d entries left required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
